seg7_scan_driver: RTL and testbench

Consumer end of the four-digit display interface: takes the 4-bit glyph codes A, B, C, D and the per-digit blank mask produced by the game's display sequencers, and time-multiplexes them onto the Basys3 common-anode four-digit seven-segment display. It latches a coherent frame at each scan-frame boundary so that mid-frame code changes cannot tear, and provides per-digit decimal points and a frame-rate blink. It sits between the game-state/sequencer blocks and the board pins.

---
 rtl/seg7_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with frame-coherent shadow
// latching, per-digit decimal points and a frame-rate blink.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] blank,
  input  logic [3:0] dp_in,
  input  logic       blink,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [3:0][3:0]     code_q, code_d;   // [3]=A ... [0]=D, indexed by idx
  logic [3:0]          blank_q, blank_d;
  logic [3:0]          dpm_q, dpm_d;
  logic                blink_en_q, blink_en_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                phase_q, phase_d; // 1 = lit half of blink
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [3:0]          an_q, an_d;

  logic wrap, boundary, lit;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  assign wrap        = (pcnt_q == PCNT_LAST);
  assign boundary    = wrap && (idx_q == 2'd3);
  assign frame_start = boundary;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      code_q     <= '0;
      blank_q    <= 4'b1111;
      dpm_q      <= '0;
      blink_en_q <= 1'b0;
      fcnt_q     <= '0;
      phase_q    <= 1'b1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      an_q       <= 4'b1111;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      blank_q    <= blank_d;
      dpm_q      <= dpm_d;
      blink_en_q <= blink_en_d;
      fcnt_q     <= fcnt_d;
      phase_q    <= phase_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  // Scan counters and frame-boundary shadow load
  always_comb begin
    pcnt_d     = wrap ? '0 : pcnt_q + 1'b1;
    idx_d      = wrap ? idx_q + 2'd1 : idx_q;
    code_d     = code_q;
    blank_d    = blank_q;
    dpm_d      = dpm_q;
    blink_en_d = blink_en_q;
    fcnt_d     = fcnt_q;
    phase_d    = phase_q;
    if (boundary) begin
      code_d     = {A, B, C, D};
      blank_d    = blank;
      dpm_d      = dp_in;
      blink_en_d = blink;
      // Blink restarts lit at counter 0 whenever it is off or newly enabled
      if (!blink || !blink_en_q) begin
        fcnt_d  = '0;
        phase_d = 1'b1;
      end else if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    lit  = !blank_q[idx_q] && phase_q;
    an_d = 4'b1111;
    seg_d = 7'h7F;
    dp_d = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = glyph(code_q[idx_q]);
      dp_d  = ~dpm_q[idx_q];
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed and random stimulus
// compared every cycle against a cycle-count based reference model.
module tb_seg7_scan_driver;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FR = 4 * RD;
  localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] A = 4'd1, B = 4'd2, C = 4'd3, D = 4'd4;
  logic [3:0] blank = 4'b0000, dp_in = 4'b0000;
  logic blink = 1'b0;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  logic frame_start;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .C(C), .D(D),
    .blank(blank), .dp_in(dp_in), .blink(blink),
    .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference state: cycle number since release, shadowed frame contents,
  // and how many consecutive boundaries have seen blink high.
  int n = 0;
  bit known = 0;
  logic [3:0] m_code [4];
  logic [3:0] m_blank, m_dp;
  bit m_ben;
  int m_run;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic e_dp;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_code[i] = 4'd0;
    m_blank = 4'b1111;
    m_dp = 4'b0000;
    m_ben = 0;
    m_run = 0;
  endtask

  // Caller sets inputs for the current cycle, then calls tick at a negedge.
  task automatic tick();
    int d;
    bit on;
    if (known) begin
      chk("an", {4'b0, an}, {4'b0, e_an});
      chk("seg", {1'b0, seg}, {1'b0, e_seg});
      chk("dp", {7'b0, dp}, {7'b0, e_dp});
      chk("frame_start", {7'b0, frame_start}, {7'b0, (n % FR) == FR - 1});
    end
    if (reset) begin
      model_reset();
      e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
      n = 0;
      known = 1;
    end else begin
      d = (n % FR) / RD;
      on = !m_ben || ((m_run / BF) % 2 == 0);
      if (m_blank[d] || !on) begin
        e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an = 4'b1111;
        e_an[d] = 1'b0;
        e_seg = GLY[m_code[d]];
        e_dp = ~m_dp[d];
      end
      if ((n % FR) == FR - 1) begin
        m_code[3] = A; m_code[2] = B; m_code[1] = C; m_code[0] = D;
        m_blank = blank;
        m_dp = dp_in;
        m_run = (blink && m_ben) ? m_run + 1 : 0;
        m_ben = blink;
      end
      n++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    model_reset();
    e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
    @(negedge clk);
    // Startup: 3 reset cycles, then codes 1,2,3,4
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(20);
    // Mid-frame change to A must not tear the current frame
    A = 4'd8;
    run(30);
    // Blank leftmost digit, decimal point on an[1]
    blank = 4'b1000;
    dp_in = 4'b0010;
    run(2 * FR);
    blank = 4'b0000;
    dp_in = 4'b0000;
    // Blink mid-frame, hold for several half-periods, then release
    run(5);
    blink = 1'b1;
    run(10 * FR);
    blink = 1'b0;
    run(3 * FR);
    // Sweep all hex codes on the rightmost digit, changing mid-frame
    for (int h = 0; h < 16; h++) begin
      D = 4'(h);
      A = 4'($urandom_range(0, 15));
      run(FR);
    end
    // Mid-frame reset at cycle 22 of a fresh startup
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(22);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(40);
    // Random traffic, including blink toggles and occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); D = 4'($urandom);
        blank = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 39) == 0) blink = ~blink;
      reset = ($urandom_range(0, 249) == 0);
      tick();
    end
    reset = 1'b0;
    run(2 * FR);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
